// File: rtl/irom_reader_if.sv
// Bus bundle for irom_reader: ROM read port (CEN/A/Q) plus the pixel valid/ready stream.
// master = the reader; slave = the ROM plus downstream consumer side.
interface irom_reader_if #(
  parameter int AW = 6,
  parameter int DW = 8
) ();
  logic          IROM_EN;
  logic [AW-1:0] IROM_A;
  logic [DW-1:0] IROM_Q;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic [AW-1:0] pix_addr;

  modport master (
    output IROM_EN, IROM_A, pix_valid, pix_data, pix_addr,
    input  IROM_Q, pix_ready
  );

  modport slave (
    input  IROM_EN, IROM_A, pix_valid, pix_data, pix_addr,
    output IROM_Q, pix_ready
  );
endinterface

// File: rtl/irom_reader.sv
// Pipelined image-ROM reader: streams all DEPTH pixels through a credit-tracked FIFO.
// Optional macro COLUMN_ORDER_EN: issue addresses column-major instead of row-major.
module irom_reader #(
  parameter int DEPTH      = 64,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_W_LOG2 = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          start,
  output logic          busy,
  output logic          done,
  irom_reader_if.master bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = AW + DATA_W;
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);
  localparam logic [FCW:0]   FIFO_CAP  = (FCW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   issued_cnt_q, issued_cnt_d;
  logic [CW-1:0]   popped_cnt_q, popped_cnt_d;
  logic            irom_en_q, irom_en_d;
  logic [AW-1:0]   irom_a_q, irom_a_d;
  logic            v1_q, v1_d;
  logic            v2_q, v2_d;
  logic [AW-1:0]   addr2_q, addr2_d;
  logic [EW-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]  fifo_count_q, fifo_count_d;

  logic [AW-1:0]   issue_addr;
  logic [FCW:0]    credit_used;
  logic            issue;
  logic            push;
  logic            pop;
  logic            fifo_nonempty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Count splits as {row, column}; column-major simply swaps the two fields.
`ifdef COLUMN_ORDER_EN
  assign issue_addr = {issued_cnt_q[IMG_W_LOG2-1:0], issued_cnt_q[AW-1:IMG_W_LOG2]};
`else
  assign issue_addr = {issued_cnt_q[AW-1:IMG_W_LOG2], issued_cnt_q[IMG_W_LOG2-1:0]};
`endif

  // Control FSM
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (issued_cnt_q == DEPTH_CNT) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (popped_cnt_q == DEPTH_CNT) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue side: a new read only goes out if the FIFO can still hold every word in flight.
  always_comb begin
    credit_used = {1'b0, fifo_count_q} + {{FCW{1'b0}}, v1_q} + {{FCW{1'b0}}, v2_q};
    issue       = (state_q == S_FETCH) && (issued_cnt_q < DEPTH_CNT) && (credit_used < FIFO_CAP);
    irom_en_d   = ~issue;
    irom_a_d    = issue ? issue_addr : irom_a_q;
    v1_d        = issue;
    v2_d        = v1_q;
    addr2_d     = v1_q ? irom_a_q : addr2_q;
  end

  // Output FIFO; capture is keyed purely on the tag pipe, not on CEN.
  always_comb begin
    fifo_nonempty = (fifo_count_q != '0);
    push          = v2_q;
    pop           = fifo_nonempty && bus.pix_ready;
    fifo_mem_d    = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = {addr2_q, bus.IROM_Q};
    wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d      = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_count_d  = fifo_count_q + FCW'(push) - FCW'(pop);
  end

  always_comb begin
    issued_cnt_d = issued_cnt_q;
    popped_cnt_d = popped_cnt_q;
    if (state_q == S_IDLE && start) begin
      issued_cnt_d = '0;
      popped_cnt_d = '0;
    end else begin
      if (issue) issued_cnt_d = issued_cnt_q + CW'(1);
      if (pop)   popped_cnt_d = popped_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      issued_cnt_q <= '0;
      popped_cnt_q <= '0;
      irom_en_q    <= 1'b1;
      irom_a_q     <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      addr2_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      issued_cnt_q <= issued_cnt_d;
      popped_cnt_q <= popped_cnt_d;
      irom_en_q    <= irom_en_d;
      irom_a_q     <= irom_a_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      addr2_q      <= addr2_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      fifo_mem_q   <= fifo_mem_d;
    end
  end

  assign bus.IROM_EN   = irom_en_q;
  assign bus.IROM_A    = irom_a_q;
  assign bus.pix_valid = fifo_nonempty;
  assign bus.pix_data  = fifo_mem_q[rd_ptr_q][DATA_W-1:0];
  assign bus.pix_addr  = fifo_mem_q[rd_ptr_q][EW-1:DATA_W];

endmodule

// File: tb/tb_irom_reader.sv
// Bench for irom_reader: negedge ROM model, per-cycle stream/issue checker, directed transfers.
// Honors COLUMN_ORDER_EN for the expected pixel order.
module tb_irom_reader;
  localparam int DEPTH = 64;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic model_clear = 1'b0;

  logic [7:0] rom [DEPTH];
  logic [5:0] rom_lat_a = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int iss_idx = 0;
  int exp_idx = 0;
  int done_cnt = 0;
  int xfer_no = 0;

  irom_reader_if #(.AW(6), .DW(8)) bus ();

  irom_reader dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ROM: address latched on negedge when CEN low, Q registered on the following negedge.
  always @(negedge CLK) begin
    bus.IROM_Q <= rom[rom_lat_a];
    if (bus.IROM_EN == 1'b0) rom_lat_a <= bus.IROM_A;
  end

  // Image order: k-th pixel of the image, as a plain row/column formula.
  function automatic int exp_addr(input int k);
`ifdef COLUMN_ORDER_EN
    return (k % 8) * 8 + (k / 8);
`else
    return k;
`endif
  endfunction

  function automatic int exp_data(input int k);
    return (exp_addr(k) ^ 'hA5) & 'hFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model: issue order, stream order/data, credit bound.
  always @(negedge CLK) begin
    if (!RESET_N || model_clear) begin
      iss_idx = 0;
      exp_idx = 0;
    end else begin
      if (bus.IROM_EN == 1'b0) begin
        if (iss_idx < DEPTH) check("issue_addr", 32'(bus.IROM_A), 32'(exp_addr(iss_idx)));
        else                 check("issue_count", 32'(iss_idx + 1), 32'(DEPTH));
        iss_idx++;
      end
      check("outstanding_le_4", 32'((iss_idx - exp_idx) <= 4), 32'd1);
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_idx < DEPTH) begin
          check("pix_addr", 32'(bus.pix_addr), 32'(exp_addr(exp_idx)));
          check("pix_data", 32'(bus.pix_data), 32'(exp_data(exp_idx)));
        end else begin
          check("pixel_count", 32'(exp_idx + 1), 32'(DEPTH));
        end
        exp_idx++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_irom_en"},  32'(bus.IROM_EN),   32'd1);
    check({tag, "_irom_a"},   32'(bus.IROM_A),    32'd0);
    check({tag, "_valid"},    32'(bus.pix_valid), 32'd0);
    check({tag, "_data"},     32'(bus.pix_data),  32'd0);
    check({tag, "_addr"},     32'(bus.pix_addr),  32'd0);
    check({tag, "_busy"},     32'(busy),          32'd0);
    check({tag, "_done"},     32'(done),          32'd0);
  endtask

  // Pulses start so that it is sampled at the next posedge; returns just after that edge.
  task automatic start_xfer();
    model_clear = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear = 1'b0;
    start_cyc = cyc;
  endtask

  // mode 0: ready high; 1: ready low for cycles 5..20; 2: ready 30%; 3: ready high + stray start
  task automatic run_xfer(input int mode, input int bound, output int lat);
    bit pulsed;
    int n;
    pulsed = 1'b0;
    lat = -1;
    for (int k = 0; k < bound; k++) begin
      n = cyc - start_cyc;
      case (mode)
        1:       bus.pix_ready = !(n >= 5 && n <= 20);
        2:       bus.pix_ready = ($urandom_range(0, 99) < 30);
        default: bus.pix_ready = 1'b1;
      endcase
      if (mode == 3) begin
        start = (exp_idx >= 20) && !pulsed;
        if (start) pulsed = 1'b1;
      end
      if (mode == 1 && n == 15) begin
        check("stall_cen_high",   32'(bus.IROM_EN),  32'd1);
        check("stall_issued",     32'(iss_idx),      32'd6);
        check("stall_popped",     32'(exp_idx),      32'd2);
        check("stall_head_valid", 32'(bus.pix_valid), 32'd1);
`ifdef COLUMN_ORDER_EN
        check("stall_head_addr",  32'(bus.pix_addr), 32'd16);
        check("stall_head_data",  32'(bus.pix_data), 32'hB5);
`else
        check("stall_head_addr",  32'(bus.pix_addr), 32'd2);
        check("stall_head_data",  32'(bus.pix_data), 32'hA7);
`endif
      end
      step();
      if (done) begin
        lat = cyc - start_cyc;
        break;
      end
    end
    start = 1'b0;
    if (mode == 3) check("stray_start_sent", 32'(pulsed), 32'd1);
    check("done_within_bound", 32'(lat >= 0), 32'd1);
  endtask

  task automatic finish_xfer(input int lat, input int req_lat, input int done_before);
    if (req_lat >= 0) check("done_latency", 32'(lat), 32'(req_lat));
    check("busy_low_at_done", 32'(busy), 32'd0);
    step();
    check("done_one_cycle",   32'(done), 32'd0);
    check("busy_low_after",   32'(busy), 32'd0);
    check("pixels_delivered", 32'(exp_idx), 32'(DEPTH));
    check("addresses_issued", 32'(iss_idx), 32'(DEPTH));
    check("done_pulses",      32'(done_cnt - done_before), 32'd1);
    xfer_no++;
    $display("xfer %0d: pixels=%0d issued=%0d latency=%0d done_pulses=%0d",
             xfer_no, exp_idx, iss_idx, lat, done_cnt - done_before);
  endtask

  initial begin
    int lat;
    int d0;
    int k;
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'(i) ^ 8'hA5;
    bus.pix_ready = 1'b0;

    step();
    step();
    check_reset_vals("reset");
    RESET_N = 1'b1;
    step();

    // Continuous read with first-pixel latency pinned
    bus.pix_ready = 1'b1;
    d0 = done_cnt;
    start_xfer();
    check("busy_at_accept", 32'(busy), 32'd1);
    check("cen_at_accept",  32'(bus.IROM_EN), 32'd1);
    step();
    check("first_cen",      32'(bus.IROM_EN), 32'd0);
    check("first_addr",     32'(bus.IROM_A),  32'd0);
    step();
    check("valid_before_q", 32'(bus.pix_valid), 32'd0);
    step();
    check("first_valid",    32'(bus.pix_valid), 32'd1);
    check("first_data",     32'(bus.pix_data),  32'hA5);
    check("first_pix_addr", 32'(bus.pix_addr),  32'd0);
    run_xfer(0, 300, lat);
    finish_xfer(lat, 68, d0);

    // Backpressure window
    step();
    d0 = done_cnt;
    start_xfer();
    run_xfer(1, 400, lat);
    finish_xfer(lat, 84, d0);

    // Random ready
    step();
    d0 = done_cnt;
    start_xfer();
    run_xfer(2, 3000, lat);
    finish_xfer(lat, -1, d0);

    // Start while busy is ignored
    step();
    d0 = done_cnt;
    start_xfer();
    run_xfer(3, 300, lat);
    finish_xfer(lat, 68, d0);

    // Asynchronous reset mid-transfer, then a clean restart
    step();
    bus.pix_ready = 1'b1;
    d0 = done_cnt;
    start_xfer();
    k = 0;
    while (exp_idx < 30 && k < 200) begin
      step();
      k++;
    end
    check("reached_pixel_30", 32'(exp_idx >= 30), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check_reset_vals("async_reset");
    step();
    step();
    RESET_N = 1'b1;
    step();
    check_reset_vals("post_reset");
    check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    start_xfer();
    run_xfer(0, 300, lat);
    finish_xfer(lat, 68, d0);

    repeat (3) step();
    check("idle_cen_high", 32'(bus.IROM_EN), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
